// File: rtl/fetch_unit.sv
// Instruction fetch unit: holds the PC, issues one instruction-memory read at a time,
// latches the returned word and computes the next PC when the decoder commits.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  s_npc,
  input  logic        zero,
  input  logic [31:0] rs_data,
  input  logic        commit,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        addr_err
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    ERR  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   pc_plus4_q, pc_plus4_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic              instr_valid_q, instr_valid_d;
  logic              imem_req_q, imem_req_d;
  logic              addr_err_q, addr_err_d;
  logic [XLEN-1:0]   br_off;
  logic [XLEN-1:0]   npc;

  // Next-PC selection; pc_plus4_q always tracks pc_q + 4, wrapping mod 2^32.
  always_comb begin
    br_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    npc    = pc_plus4_q;
    case (s_npc)
      2'b00:   npc = zero ? XLEN'(pc_plus4_q + br_off) : pc_plus4_q;
      2'b01:   npc = {pc_plus4_q[31:28], instr_q[25:0], 2'b00};
      2'b10:   npc = rs_data;
      default: npc = pc_plus4_q;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pc_plus4_d    = pc_plus4_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    imem_req_d    = imem_req_q;
    addr_err_d    = addr_err_q;
    case (state_q)
      IDLE: begin
        imem_req_d = 1'b1;
        state_d    = REQ;
      end
      REQ: begin
        if (imem_rvalid) begin
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          imem_req_d    = 1'b0;
          state_d       = HOLD;
        end
      end
      HOLD: begin
        if (commit) begin
          instr_valid_d = 1'b0;
          // A misaligned target is fatal: keep the PC and stop fetching.
          if (npc[1:0] != 2'b00) begin
            addr_err_d = 1'b1;
            imem_req_d = 1'b0;
            state_d    = ERR;
          end else begin
            pc_d       = npc;
            pc_plus4_d = XLEN'(npc + 32'd4);
            imem_req_d = 1'b1;
            state_d    = REQ;
          end
        end
      end
      default: begin
        state_d = ERR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      pc_plus4_q    <= XLEN'(RESET_PC + 32'd4);
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      imem_req_q    <= 1'b0;
      addr_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pc_plus4_q    <= pc_plus4_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      imem_req_q    <= imem_req_d;
      addr_err_q    <= addr_err_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_plus4_q;
  assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed fetch/commit sequence, expected
// fetch addresses and latched instructions queued, checked by a monitor.
module tb_fetch_unit;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  s_npc;
  logic        zero;
  logic [31:0] rs_data;
  logic        commit;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        addr_err;

  int n_cmp = 0;
  int n_err = 0;
  exp_t        exp_q[$];
  logic [31:0] addr_q[$];

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_npc       (s_npc),
    .zero        (zero),
    .rs_data     (rs_data),
    .commit      (commit),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .addr_err    (addr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations on a new request and on a newly valid instruction.
  logic        prev_req = 1'b0;
  logic        prev_valid = 1'b0;
  logic [31:0] prev_addr = '0;
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] a;
    if (!rst_n) begin
      prev_req   = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (prev_req && imem_req) chk("addr_stable", imem_addr, prev_addr);
      if (imem_req && !prev_req) begin
        if (addr_q.size() == 0) chk("unexpected_req", 32'd1, 32'd0);
        else begin
          a = addr_q.pop_front();
          chk("imem_addr", imem_addr, a);
        end
      end
      if (instr_valid && !prev_valid) begin
        if (exp_q.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("instr", instr, e.instr);
          chk("pc", pc, e.pc);
          chk("pc_plus4", pc_plus4, e.pc_plus4);
        end
      end
      prev_req   = imem_req;
      prev_valid = instr_valid;
      prev_addr  = imem_addr;
    end
  end

  task automatic fetch(input logic [31:0] addr, input logic [31:0] word, input int dly);
    int t = 0;
    exp_q.push_back('{instr: word, pc: addr, pc_plus4: addr + 32'd4});
    while (!imem_req && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!imem_req) begin
      chk("req_timeout", 32'd0, 32'd1);
      return;
    end
    repeat (dly) @(negedge clk);
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    chk("latency_valid", 32'(instr_valid), 32'd1);
  endtask

  task automatic do_commit(input logic [1:0] sel, input logic z, input logic [31:0] rs,
                           input logic [31:0] exp_addr, input bit expect_fetch);
    if (expect_fetch) addr_q.push_back(exp_addr);
    s_npc   = sel;
    zero    = z;
    rs_data = rs;
    commit  = 1'b1;
    @(negedge clk);
    commit  = 1'b0;
    s_npc   = 2'b11;
    zero    = 1'b0;
    rs_data = '0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_pc", pc, 32'h0000_3000);
    chk("rst_instr", instr, 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_err", 32'(addr_err), 32'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    s_npc       = 2'b11;
    zero        = 1'b0;
    rs_data     = '0;
    commit      = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    repeat (2) @(negedge clk);
    chk_reset_vals();
    addr_q.push_back(32'h0000_3000);
    rst_n = 1'b1;

    fetch(32'h0000_3000, 32'h2008_0005, 2);
    // Stray rvalid while holding must not overwrite instr.
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk("hold_instr", instr, 32'h2008_0005);
    chk("hold_valid", 32'(instr_valid), 32'd1);

    do_commit(2'b11, 1'b0, 32'd0, 32'h0000_3004, 1'b1);
    // Commit while a request is outstanding is ignored.
    do_commit(2'b10, 1'b0, 32'h0000_3002, 32'd0, 1'b0);
    chk("req_commit_err", 32'(addr_err), 32'd0);
    chk("req_commit_pc", pc, 32'h0000_3004);
    fetch(32'h0000_3004, 32'h1000_FFFF, 1);

    do_commit(2'b00, 1'b1, 32'd0, 32'h0000_3004, 1'b1);
    fetch(32'h0000_3004, 32'h1000_FFFF, 0);
    do_commit(2'b00, 1'b0, 32'd0, 32'h0000_3008, 1'b1);
    fetch(32'h0000_3008, 32'h0000_0020, 1);
    do_commit(2'b11, 1'b0, 32'd0, 32'h0000_300C, 1'b1);
    fetch(32'h0000_300C, 32'h2129_0001, 0);
    do_commit(2'b11, 1'b0, 32'd0, 32'h0000_3010, 1'b1);
    fetch(32'h0000_3010, 32'h0C00_0C10, 2);
    do_commit(2'b01, 1'b0, 32'd0, 32'h0000_3040, 1'b1);
    fetch(32'h0000_3040, 32'h03E0_0008, 0);
    do_commit(2'b10, 1'b0, 32'h0000_3000, 32'h0000_3000, 1'b1);
    fetch(32'h0000_3000, 32'h2008_0005, 1);

    // PC wrap at the top of the address space.
    do_commit(2'b10, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1);
    fetch(32'hFFFF_FFFC, 32'h1000_0003, 0);
    do_commit(2'b00, 1'b1, 32'd0, 32'h0000_000C, 1'b1);
    fetch(32'h0000_000C, 32'h0800_0C00, 0);

    // Misaligned jr target enters the terminal error state.
    do_commit(2'b10, 1'b0, 32'h0000_3002, 32'd0, 1'b0);
    chk("err_flag", 32'(addr_err), 32'd1);
    chk("err_req", 32'(imem_req), 32'd0);
    chk("err_pc", pc, 32'h0000_000C);
    chk("err_valid", 32'(instr_valid), 32'd0);
    commit      = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1234_5678;
    repeat (3) @(negedge clk);
    commit      = 1'b0;
    imem_rvalid = 1'b0;
    chk("err_stuck_flag", 32'(addr_err), 32'd1);
    chk("err_stuck_pc", pc, 32'h0000_000C);
    chk("err_stuck_instr", instr, 32'h0800_0C00);
    chk("err_stuck_req", 32'(imem_req), 32'd0);

    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    @(negedge clk);
    addr_q.push_back(32'h0000_3000);
    rst_n = 1'b1;
    fetch(32'h0000_3000, 32'h2008_0005, 0);

    // Reset mid-fetch, then a late rvalid arriving in IDLE is dropped.
    do_commit(2'b11, 1'b0, 32'd0, 32'h0000_3004, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    addr_q.push_back(32'h0000_3000);
    rst_n       = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_BAD0;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    chk("late_rvalid_valid", 32'(instr_valid), 32'd0);
    chk("late_rvalid_instr", instr, 32'd0);
    fetch(32'h0000_3000, 32'h2008_0005, 1);

    repeat (2) @(negedge clk);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("addr_q_drained", 32'(addr_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
